// File: rtl/cpu_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: state codes,
// the reset-time instruction register value and the opcodes it dispatches on.
package cpu_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd7
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          WAIT_CNT_W = 8;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

    // Legal opcodes that skip the data-memory phase.
    function automatic logic is_direct_op(input logic [6:0] op);
        return (op == OPCODE_OP)  || (op == OPCODE_OP_IMM) || (op == OPCODE_LUI) ||
               (op == OPCODE_JAL) || (op == OPCODE_JALR)   || (op == OPCODE_BRANCH);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_wait_timer.sv
// Memory wait counter shared by the fetch and data-access phases; flags the
// last permitted wait cycle so the sequencer can trap on a stalled request.
module wait_timer
    import cpu_control_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WAIT_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WAIT_CNT_W'(1);
        end
    end

    assign o_expired = (r_count == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: owns PC, instruction register and retire
// counter, drives the memory handshakes and traps into a sticky fault state.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic        write_enable,
    input  logic        mem_write_enable,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic        fault
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;

    logic        w_waiting;
    logic        w_ready;
    logic        w_expired;
    logic [31:0] w_next_pc;
    logic        w_next_aligned;

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_ready   = (r_state == ST_FETCH) ? imem_ready : dmem_ready;

    // Held clear outside the two waiting states, so it restarts on every entry.
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_waiting),
        .i_enable  (w_waiting && !w_ready),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (opcode)
            OPCODE_JAL:    w_next_pc = r_pc + imm;
            OPCODE_JALR:   w_next_pc = {alu_result[31:1], 1'b0};
            OPCODE_BRANCH: if (branch_taken) w_next_pc = r_pc + imm;
            default:       ;
        endcase
    end

    assign w_next_aligned = (w_next_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_instret <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= ST_DECODE;
                    end else if (w_expired) begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_DECODE: r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (is_mem_op(opcode)) begin
                        r_state <= ST_MEM;
                    end else if (is_direct_op(opcode)) begin
                        r_state <= ST_WRITEBACK;
                    end else begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        r_state <= ST_WRITEBACK;
                    end else if (w_expired) begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_WRITEBACK: begin
                    if (w_next_aligned) begin
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + 32'd1;
                        r_state   <= ST_FETCH;
                    end else begin
                        r_state <= ST_FAULT;
                    end
                end
                default: r_state <= ST_FAULT;
            endcase
        end
    end

    // Strobes decode the state register and are silenced combinationally by rst.
    assign imem_req  = !rst && (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign dmem_req  = !rst && (r_state == ST_MEM);
    assign dmem_we   = dmem_req && mem_write_enable;
    assign rf_we     = !rst && (r_state == ST_WRITEBACK) && w_next_aligned && write_enable;
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign instret   = r_instret;
    assign state     = r_state;
    assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: the driver plays memory and decoder,
// a rule-level model predicts each instruction's outcome, a monitor compares.
module tb_cpu_control_fsm;

    localparam int          TO        = 16;
    localparam logic [31:0] RPC       = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BR     = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [6:0]  opcode = OP_I;
    logic        write_enable = 1'b0;
    logic        mem_write_enable = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [2:0]  state;
    logic        fault;

    always #5 clk = ~clk;

    cpu_control_fsm #(
        .RESET_PC (RPC),
        .TIMEOUT  (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .opcode           (opcode),
        .write_enable     (write_enable),
        .mem_write_enable (mem_write_enable),
        .branch_taken     (branch_taken),
        .imm              (imm),
        .alu_result       (alu_result),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_ready       (dmem_ready),
        .rf_we            (rf_we),
        .pc               (pc),
        .instret          (instret),
        .state            (state),
        .fault            (fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        fault;
        int          pulses;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_pc      = RPC;
    logic [31:0] m_instret = 32'h0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, expv);
    endtask

    // Outcome of one instruction from the architectural rules and the memory delays.
    function automatic exp_t predict(input logic [6:0] op, input logic [31:0] off, input bit taken,
                                     input logic [31:0] alu, input bit we, input int iw, input int dw);
        exp_t        e;
        bit          is_mem;
        bit          legal;
        logic [31:0] tgt;
        is_mem   = (op == OP_LOAD) || (op == OP_STORE);
        legal    = is_mem || (op inside {OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_BR});
        e.pc      = m_pc;
        e.instret = m_instret;
        e.fault   = 1'b1;
        e.pulses  = 0;
        if (iw >= TO) begin
            e.cycles = TO;
            return e;
        end
        if (!legal) begin
            e.cycles = 3 + iw;
            return e;
        end
        if (is_mem && dw >= TO) begin
            e.cycles = 3 + iw + TO;
            return e;
        end
        e.cycles = 4 + iw + (is_mem ? 1 + dw : 0);
        if (op == OP_JAL)                tgt = m_pc + off;
        else if (op == OP_JALR)          tgt = alu & 32'hFFFF_FFFE;
        else if (op == OP_BR && taken)   tgt = m_pc + off;
        else                             tgt = m_pc + 32'd4;
        if (tgt % 4 != 0) return e;
        e.pc      = tgt;
        e.instret = m_instret + 32'd1;
        e.fault   = 1'b0;
        e.pulses  = we ? 1 : 0;
        return e;
    endfunction

    // Monitor: an instruction ends when instret moves or fault rises.
    int          mon_cyc    = 0;
    int          mon_pulses = 0;
    logic [31:0] mon_last_instret = 32'h0;
    logic        mon_last_fault   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_cyc          = 0;
            mon_pulses       = 0;
            mon_last_instret = instret;
            mon_last_fault   = fault;
        end else begin
            if (instret !== mon_last_instret || (fault === 1'b1 && mon_last_fault !== 1'b1)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_event: pc=%h instret=%h fault=%b with no expectation queued",
                             pc, instret, fault);
                end else begin
                    e = exp_q.pop_front();
                    chk32("sb_pc", pc, e.pc);
                    chk32("sb_instret", instret, e.instret);
                    chk1("sb_fault", fault, e.fault);
                    chk32("sb_rf_we_pulses", mon_pulses, e.pulses);
                    chk32("sb_cycles", mon_cyc, e.cycles);
                end
                mon_cyc    = 1;
                mon_pulses = 0;
            end else begin
                mon_cyc++;
            end
            if (rf_we === 1'b1) mon_pulses++;
            mon_last_instret = instret;
            mon_last_fault   = fault;
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_dmem_req", dmem_req, 1'b0);
        chk1("rst_dmem_we", dmem_we, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        @(posedge clk); #1;
        chk32("rst_state", {29'b0, state}, 32'd0);
        chk32("rst_pc", pc, RPC);
        chk32("rst_instr", instr, NOP);
        chk32("rst_instret", instret, 32'd0);
        chk1("rst_fault", fault, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b0;
        m_pc      = RPC;
        m_instret = 32'h0;
        #1;
        chk1("post_rst_imem_req", imem_req, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [31:0] off, input bit taken,
                             input logic [31:0] alu, input bit we, input bit mwe, input int iw, input int dw);
        exp_t        e;
        logic [31:0] rdata;
        bit          is_mem;
        e      = predict(op, off, taken, alu, we, iw, dw);
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        exp_q.push_back(e);
        opcode           = op;
        imm              = off;
        branch_taken     = taken;
        alu_result       = alu;
        write_enable     = we;
        mem_write_enable = mwe;
        rdata            = $urandom;
        imem_rdata       = rdata;
        for (int i = 0; i <= iw; i++) begin
            if (i < TO) begin
                chk1("fetch_imem_req", imem_req, 1'b1);
                chk32("fetch_imem_addr", imem_addr, m_pc);
            end
            imem_ready = (i == iw);
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        if (iw < TO) chk32("fetch_instr", instr, rdata);
        repeat (2) @(posedge clk);
        #1;
        if (is_mem) begin
            for (int i = 0; i <= dw; i++) begin
                if (i < TO && iw < TO) begin
                    chk1("mem_dmem_req", dmem_req, 1'b1);
                    chk1("mem_dmem_we", dmem_we, mwe);
                end
                dmem_ready = (i == dw);
                @(posedge clk); #1;
            end
            dmem_ready = 1'b0;
        end
        @(posedge clk); #1;
        if (e.fault) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk1("fault_imem_req", imem_req, 1'b0);
            chk1("fault_dmem_req", dmem_req, 1'b0);
            chk1("fault_dmem_we", dmem_we, 1'b0);
            chk1("fault_rf_we", rf_we, 1'b0);
            chk1("fault_sticky", fault, 1'b1);
            chk32("fault_state", {29'b0, state}, 32'd7);
            chk32("fault_pending_events", exp_q.size(), 32'd0);
            exp_q.delete();
            do_reset();
        end else begin
            m_pc      = e.pc;
            m_instret = e.instret;
        end
    endtask

    task automatic mid_mem_reset();
        opcode           = OP_STORE;
        write_enable     = 1'b0;
        mem_write_enable = 1'b1;
        imem_ready       = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("midmem_dmem_req", dmem_req, 1'b1);
        chk1("midmem_dmem_we", dmem_we, 1'b1);
        do_reset();
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        return $urandom_range(0, 2);
    endfunction

    initial begin
        logic [6:0]  ops[9];
        logic [6:0]  op;
        logic [31:0] off;
        logic [31:0] alu;
        int          k;
        ops = '{OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, 7'h7F};

        do_reset();
        run_instr(OP_I, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_STORE, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 3);
        run_instr(OP_JAL, 32'h10 - m_pc, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_BR, 32'hFFFF_FFF8, 1'b1, 32'h0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JAL, 32'h10 - m_pc, 1'b0, 32'h0, 1'b0, 1'b0, 1, 0);
        run_instr(OP_BR, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JALR, 32'h0, 1'b0, 32'h103, 1'b1, 1'b0, 0, 0);
        run_instr(OP_I, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, TO - 1, 0);
        run_instr(OP_I, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, TO, 0);
        run_instr(7'h7F, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, TO - 1);
        run_instr(OP_STORE, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 0, TO);
        mid_mem_reset();

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 19);
            op = (k < 8) ? ops[k] : ((k == 19) ? ops[8] : ops[k % 8]);
            off = ($urandom_range(0, 63) << 2) - 32'd128;
            if ($urandom_range(0, 9) == 0) off = off + 32'd2;
            alu = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 7) == 0) alu = alu | 32'h2;
            run_instr(op, off, 1'($urandom_range(0, 1)), alu, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), pick_wait(), pick_wait());
        end

        repeat (3) @(posedge clk);
        #1;
        chk32("final_pending_events", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
